// File: rtl/tinyqv_irq_ctrl.sv
// Nibble-serial interrupt controller for TinyQV: edge/level channels, mie/mip CSR nibbles, cause latch.
// Optional build macro TINYQV_IRQ_AUTOCLEAR_EN clears the taken edge channel's pending bit on trap entry.
module tinyqv_irq_ctrl #(
    parameter int          NUM_IRQ   = 4,
    parameter logic [15:0] EDGE_MASK = 16'h0003
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         counter,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               csr_sel_mie,
    input  logic               csr_sel_mip,
    input  logic [1:0]         csr_op,
    input  logic [3:0]         csr_wdata,
    output logic [3:0]         csr_rdata,
    input  logic               global_ie,
    input  logic               take_irq,
    input  logic               clear_all,
    output logic               interrupt_pending,
    output logic [3:0]         irq_cause
);

    localparam int                 NUM_NIB = NUM_IRQ / 4;
    localparam logic [NUM_IRQ-1:0] EDGE_CH = EDGE_MASK[NUM_IRQ-1:0];

    logic [NUM_IRQ-1:0] mie_reg, mie_next;
    logic [NUM_IRQ-1:0] pend_reg, pend_next;
    logic [NUM_IRQ-1:0] irq_d_reg;
    logic [3:0]         irq_cause_reg;

    logic [NUM_IRQ-1:0] mip;
    logic [NUM_IRQ-1:0] active;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] autoclr;
    logic [3:0]         cause_next;
    logic               cause_found;
    logic               nib_active;
    logic               take_now;

    function automatic logic apply_op(input logic cur, input logic w, input logic [1:0] op);
        case (op)
            2'b01:   return w;
            2'b10:   return cur | w;
            2'b11:   return cur & ~w;
            default: return cur;
        endcase
    endfunction

    // Nibble k of the CSR lives at counter 4+k; counters 0..3 and unused nibbles are inert.
    assign nib_active = counter[2] && ({1'b0, counter[1:0]} < 3'(NUM_NIB));
    assign take_now   = take_irq && (counter == 3'd0);

    // Level channels never store state: their mip bit is the live request line.
    assign mip    = (pend_reg & EDGE_CH) | (irq_in & ~EDGE_CH);
    assign active = mip & mie_reg;
    assign rise   = irq_in & ~irq_d_reg;

    assign interrupt_pending = global_ie && (|active);
    assign irq_cause         = irq_cause_reg;

    always_comb begin
        cause_next  = 4'd0;
        cause_found = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i]) begin
                cause_next  = 4'(i);
                cause_found = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_ch
            logic nib_hit;
            logic pend_csr;

            assign nib_hit = nib_active && (counter[1:0] == 2'(gi / 4));

            assign mie_next[gi] = (csr_sel_mie && nib_hit)
                                ? apply_op(mie_reg[gi], csr_wdata[gi % 4], csr_op)
                                : mie_reg[gi];

            // mie takes precedence when both selects are (illegally) raised.
            assign pend_csr = (csr_sel_mip && !csr_sel_mie && nib_hit)
                            ? apply_op(pend_reg[gi], csr_wdata[gi % 4], csr_op)
                            : pend_reg[gi];

`ifdef TINYQV_IRQ_AUTOCLEAR_EN
            assign autoclr[gi] = take_now && cause_found && (cause_next == 4'(gi));
`else
            assign autoclr[gi] = 1'b0;
`endif

            // A fresh edge overrides any clear arriving in the same clock.
            assign pend_next[gi] = EDGE_CH[gi] & ((pend_csr & ~autoclr[gi]) | rise[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_reg       <= '0;
            pend_reg      <= '0;
            irq_d_reg     <= '0;
            irq_cause_reg <= 4'd0;
        end else begin
            irq_d_reg <= irq_in;
            if (take_now) begin
                irq_cause_reg <= cause_found ? cause_next : 4'd0;
            end
            if (clear_all) begin
                mie_reg  <= '0;
                pend_reg <= '0;
            end else begin
                mie_reg  <= mie_next;
                pend_reg <= pend_next;
            end
        end
    end

    logic [15:0] mie_wide;
    logic [15:0] mip_wide;
    assign mie_wide = 16'(mie_reg);
    assign mip_wide = 16'(mip);

    always_comb begin
        csr_rdata = 4'd0;
        if (nib_active) begin
            if (csr_sel_mie) begin
                csr_rdata = mie_wide[{counter[1:0], 2'b00} +: 4];
            end else if (csr_sel_mip) begin
                csr_rdata = mip_wide[{counter[1:0], 2'b00} +: 4];
            end
        end
    end

endmodule

// File: tb/tb_tinyqv_irq_ctrl.sv
// Bench for tinyqv_irq_ctrl (16 channels, channels 0/1 edge): directed scenarios plus random traffic
// compared every cycle against a 32-bit CSR-level model.
module tb_tinyqv_irq_ctrl;

    localparam logic [15:0] EDGE = 16'h0003;
    localparam logic [31:0] EDGE32 = {EDGE, 16'h0000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  counter = 3'd0;
    logic [15:0] irq_in = 16'h0;
    logic        csr_sel_mie = 1'b0;
    logic        csr_sel_mip = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [3:0]  csr_wdata = 4'h0;
    logic [3:0]  csr_rdata;
    logic        global_ie = 1'b0;
    logic        take_irq = 1'b0;
    logic        clear_all = 1'b0;
    logic        interrupt_pending;
    logic [3:0]  irq_cause;

    int total = 0;
    int bad = 0;

    tinyqv_irq_ctrl #(.NUM_IRQ(16), .EDGE_MASK(EDGE)) dut (
        .clk(clk),
        .rst(rst),
        .counter(counter),
        .irq_in(irq_in),
        .csr_sel_mie(csr_sel_mie),
        .csr_sel_mip(csr_sel_mip),
        .csr_op(csr_op),
        .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata),
        .global_ie(global_ie),
        .take_irq(take_irq),
        .clear_all(clear_all),
        .interrupt_pending(interrupt_pending),
        .irq_cause(irq_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Model: mie and pending held as 32-bit CSR images (channel i at bit 16+i).
    bit [31:0] m_mie = 0;
    bit [31:0] m_pend = 0;
    bit [15:0] m_d = 0;
    bit [3:0]  m_cause = 0;
    bit        model_ok = 0;

    function automatic bit [31:0] m_mip();
        return (m_pend & EDGE32) | ({irq_in, 16'h0000} & ~EDGE32);
    endfunction

    function automatic bit [31:0] csr_apply(bit [31:0] v, bit [31:0] mask, bit [31:0] w, bit [1:0] op);
        case (op)
            2'b01:   return (v & ~mask) | w;
            2'b10:   return v | w;
            2'b11:   return v & ~w;
            default: return v;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mie = 0; m_pend = 0; m_d = 0; m_cause = 0;
            model_ok = 1;
        end else begin
            bit [31:0] act, n_mie, n_pend, mask, w32;
            bit        found;
            int        sh;
            act = m_mip() & m_mie;
            found = 0;
            if (counter == 3'd0 && take_irq) begin
                m_cause = 0;
                for (int i = 0; i < 16; i++)
                    if (!found && act[16+i]) begin m_cause = 4'(i); found = 1; end
            end
            n_mie = m_mie;
            n_pend = m_pend;
            if (counter >= 3'd4) begin
                sh = 16 + 4 * (int'(counter) - 4);
                mask = 32'hF << sh;
                w32 = {28'h0, csr_wdata} << sh;
                if (csr_sel_mie) n_mie = csr_apply(n_mie, mask, w32, csr_op);
                else if (csr_sel_mip) n_pend = csr_apply(n_pend, mask, w32, csr_op);
            end
`ifdef TINYQV_IRQ_AUTOCLEAR_EN
            if (found) n_pend[16 + int'(m_cause)] = 1'b0;
`endif
            n_pend = (n_pend | {irq_in & ~m_d, 16'h0000}) & EDGE32;
            if (clear_all) begin n_mie = 0; n_pend = 0; end
            m_mie = n_mie;
            m_pend = n_pend;
            m_d = irq_in;
        end
    end

    // Single compare point: mid-cycle, inputs stable since posedge+1.
    always @(negedge clk) begin
        if (model_ok) begin
            bit [31:0] src;
            bit [3:0]  exp_rd;
            src = csr_sel_mie ? m_mie : (csr_sel_mip ? m_mip() : 32'h0);
            exp_rd = (counter >= 3'd4) ? 4'(src >> (16 + 4 * (int'(counter) - 4))) : 4'h0;
            check("rdata", 16'(csr_rdata), 16'(exp_rd));
            check("pending", 16'(interrupt_pending), 16'(global_ie && |(m_mip() & m_mie)));
            check("cause", 16'(irq_cause), 16'(m_cause));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        counter = counter + 3'd1;
        csr_sel_mie = 1'b0;
        csr_sel_mip = 1'b0;
        csr_op = 2'b00;
        csr_wdata = 4'h0;
        take_irq = 1'b0;
        clear_all = 1'b0;
    endtask

    task automatic go_to(input logic [2:0] c);
        do tick(); while (counter != c);
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;

        // Reset state: both CSRs read zero on every counter slot.
        go_to(3'd0);
        for (int i = 0; i < 16; i++) begin
            if (i != 0) tick();
            csr_sel_mie = (i < 8);
            csr_sel_mip = (i >= 8);
            #2;
            check("reset_read", 16'(csr_rdata), 16'h0);
            check("reset_pend", 16'(interrupt_pending), 16'h0);
        end

        // mie nibble 0 = F, edge pulse on channel 0.
        go_to(3'd4); csr_sel_mie = 1; csr_op = 2'b01; csr_wdata = 4'hF;
        tick(); irq_in[0] = 1; global_ie = 1;
        tick(); irq_in[0] = 0; #2;
        check("edge0_pending", 16'(interrupt_pending), 16'h1);
        go_to(3'd4); csr_sel_mip = 1; #2;
        check("mip_nib0", 16'(csr_rdata), 16'h1);

        // Priority between edge 1 and level 2, then software clear of 1.
        tick(); irq_in[2] = 1;
        go_to(3'd4); csr_sel_mie = 1; csr_op = 2'b01; csr_wdata = 4'h6;
        tick(); irq_in[1] = 1;
        tick(); irq_in[1] = 0;
        go_to(3'd0); take_irq = 1;
        tick(); #2;
        check("cause_1", 16'(irq_cause), 16'h1);
        go_to(3'd4); csr_sel_mip = 1; csr_op = 2'b11; csr_wdata = 4'h2;
        go_to(3'd0); take_irq = 1;
        tick(); #2;
        check("cause_2", 16'(irq_cause), 16'h2);

        // Edge and mip clear on the same bit: edge wins.
        go_to(3'd4); csr_sel_mip = 1; csr_op = 2'b11; csr_wdata = 4'h1; irq_in[0] = 1;
        tick(); irq_in[0] = 0;
        go_to(3'd4); csr_sel_mip = 1; #2;
        check("edge_beats_clr", 16'(csr_rdata), 16'h5);

        // clear_all wipes mie and pending but keeps the cause.
        tick(); irq_in[2] = 0;
        go_to(3'd4);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) tick();
            csr_sel_mie = 1; csr_op = 2'b01; csr_wdata = 4'hF;
        end
        tick(); irq_in[1] = 1;
        tick(); irq_in[1] = 0; #2;
        check("pre_clear_pend", 16'(interrupt_pending), 16'h1);
        tick(); clear_all = 1;
        tick(); #2;
        check("clear_pend", 16'(interrupt_pending), 16'h0);
        check("clear_cause", 16'(irq_cause), 16'h2);
        go_to(3'd4);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) tick();
            csr_sel_mie = 1; #2;
            check("clear_mie", 16'(csr_rdata), 16'h0);
        end
        go_to(3'd4); csr_sel_mip = 1; #2;
        check("clear_mip", 16'(csr_rdata), 16'h0);

        // Trap on channel 0; pending survives only without auto-clear.
        go_to(3'd4); csr_sel_mie = 1; csr_op = 2'b01; csr_wdata = 4'h1;
        tick(); irq_in[0] = 1;
        tick(); irq_in[0] = 0;
        go_to(3'd0); take_irq = 1;
        tick(); #2;
        check("cause_0", 16'(irq_cause), 16'h0);
        go_to(3'd4); csr_sel_mip = 1; #2;
`ifdef TINYQV_IRQ_AUTOCLEAR_EN
        check("autoclr_mip", 16'(csr_rdata), 16'h0);
`else
        check("keep_mip", 16'(csr_rdata), 16'h1);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int sel;
            tick();
            rst = ($urandom_range(0, 199) == 0);
            irq_in = irq_in ^ 16'($urandom & $urandom & $urandom);
            sel = int'($urandom_range(0, 3));
            csr_sel_mie = (sel == 1);
            csr_sel_mip = (sel == 2);
            csr_op = 2'($urandom);
            csr_wdata = 4'($urandom);
            take_irq = ($urandom_range(0, 3) == 0);
            clear_all = ($urandom_range(0, 63) == 0);
            global_ie = ($urandom_range(0, 3) != 0);
        end
        tick();
        @(negedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
